// File: rtl/bcd_scan_display_pkg.sv
// Shared seven-segment pattern constants and scan FSM encodings.
// Patterns are {g,f,e,d,c,b,a}, active-high.
package bcd_scan_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } scan_state_t;

    // Counter width that holds 0..max(a,b,2)-1 without wrapping.
    function automatic int dwell_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/bcd_scan_display_seg7.sv
// BCD to seven-segment decoder, purely combinational; codes 10..15 show a dash.
module bcd_to_seg7
    import bcd_scan_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed 7-segment scanner with inter-digit blanking gap and
// optional leading-zero suppression; frame = 1 + 4*(SCAN_DIV+BLANK_CLKS) clocks.
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CLKS = 16
) (
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic [15:0] digits,
    input  logic        blank_zeros,
    output logic [6:0]  seg,
    output logic [3:0]  digit_en,
    output logic        frame_tick
);

    localparam int CW = dwell_width(SCAN_DIV, BLANK_CLKS);

    // state names the slot being entered on the next edge; outputs for that
    // slot are registered on the same edge.
    scan_state_t   state;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [15:0]   snapshot;
    logic          blank_en;

    logic [3:0]    cur_digit;
    logic [6:0]    cur_seg;
    logic [3:0]    nz;
    logic [3:0]    lead_blank;
    logic          cur_blanked;
    logic          last_show;
    logic          last_gap;

    assign cur_digit = snapshot[{idx, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    // Invalid codes are nonzero, so they stop blanking like any other digit.
    always_comb begin
        for (int i = 0; i < 4; i++) nz[i] = |snapshot[i*4 +: 4];
        lead_blank[3] = ~nz[3];
        lead_blank[2] = ~nz[3] & ~nz[2];
        lead_blank[1] = ~nz[3] & ~nz[2] & ~nz[1];
        lead_blank[0] = 1'b0;
    end

    assign cur_blanked = blank_en & lead_blank[idx];
    assign last_show   = (cnt == CW'(SCAN_DIV - 1));
    assign last_gap    = (cnt == CW'(BLANK_CLKS - 1));

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state      <= ST_LOAD;
            idx        <= 2'd0;
            cnt        <= '0;
            snapshot   <= 16'h0000;
            blank_en   <= 1'b0;
            seg        <= SEG_BLANK;
            digit_en   <= 4'b0000;
            frame_tick <= 1'b0;
        end else begin
            seg        <= SEG_BLANK;
            digit_en   <= 4'b0000;
            frame_tick <= 1'b0;
            case (state)
                ST_LOAD: begin
                    snapshot   <= digits;
                    blank_en   <= blank_zeros;
                    idx        <= 2'd0;
                    cnt        <= '0;
                    frame_tick <= 1'b1;
                    state      <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (!cur_blanked) begin
                        seg      <= cur_seg;
                        digit_en <= 4'b0001 << idx;
                    end
                    if (last_show) begin
                        cnt <= '0;
                        if (BLANK_CLKS > 0) begin
                            state <= ST_GAP;
                        end else if (idx == 2'd3) begin
                            state <= ST_LOAD;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (last_gap) begin
                        cnt <= '0;
                        if (idx == 2'd3) begin
                            state <= ST_LOAD;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= ST_SHOW;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed checks of bcd_scan_display with SCAN_DIV=4, BLANK_CLKS=2 (25-clock frame).
module tb_bcd_scan_display;

    logic        sys_clk = 1'b0;
    logic        sys_reset = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic        blank_zeros = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  digit_en;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    bcd_scan_display #(.SCAN_DIV(4), .BLANK_CLKS(2)) dut (
        .sys_clk     (sys_clk),
        .sys_reset   (sys_reset),
        .digits      (digits),
        .blank_zeros (blank_zeros),
        .seg         (seg),
        .digit_en    (digit_en),
        .frame_tick  (frame_tick)
    );

    always #5 sys_clk = ~sys_clk;

    // Expected {frame_tick, digit_en, seg} at frame offset pos (0 = LOAD cycle).
    // segs = {d3,d2,d1,d0} hand-decoded patterns; mask = digits actually lit.
    function automatic logic [11:0] exp_at(input int pos, input logic [27:0] segs,
                                           input logic [3:0] mask);
        int p, d;
        if (pos == 0) return {1'b1, 4'b0000, 7'h00};
        p = pos - 1;
        d = p / 6;
        if ((p % 6) < 4 && mask[d]) return {1'b0, 4'(1 << d), segs[d*7 +: 7]};
        return 12'h000;
    endfunction

    // Enter reset at a negedge, hold 3 clocks, release at a negedge.
    task automatic hold_reset();
        @(negedge sys_clk);
        sys_reset = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        sys_reset = 1'b1;
        digits = 16'h1234;
        blank_zeros = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            checks++;
            if ({frame_tick, digit_en, seg} !== 12'h000) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got tick=%b en=%b seg=%h want all 0",
                         k, frame_tick, digit_en, seg);
            end
        end
        sys_reset = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge sys_clk);
            checks++;
            if (frame_tick !== ((k == 1) || (k == 26))) begin
                errors++;
                $display("FAIL frame_tick cyc=%0d got %b want %b", k, frame_tick,
                         (k == 1) || (k == 26));
            end
        end
    endtask

    task automatic test_pattern();
        logic [11:0] e;
        digits = 16'h1234;
        blank_zeros = 1'b0;
        hold_reset();
        for (int k = 1; k <= 50; k++) begin
            @(negedge sys_clk);
            e = exp_at((k - 1) % 25, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1111);
            checks++;
            if ({frame_tick, digit_en, seg} !== e) begin
                errors++;
                $display("FAIL pattern_1234 cyc=%0d got %b_%b_%h want %h",
                         k, frame_tick, digit_en, seg, e);
            end
        end
    endtask

    task automatic test_blanking();
        logic [11:0] e;
        digits = 16'h0070;
        blank_zeros = 1'b1;
        hold_reset();
        for (int k = 1; k <= 25; k++) begin
            @(negedge sys_clk);
            e = exp_at(k - 1, {7'h3F, 7'h3F, 7'h07, 7'h3F}, 4'b0011);
            checks++;
            if ({frame_tick, digit_en, seg} !== e) begin
                errors++;
                $display("FAIL blank_0070 cyc=%0d got %b_%b_%h want %h",
                         k, frame_tick, digit_en, seg, e);
            end
        end
        blank_zeros = 1'b0;
        hold_reset();
        for (int k = 1; k <= 25; k++) begin
            @(negedge sys_clk);
            e = exp_at(k - 1, {7'h3F, 7'h3F, 7'h07, 7'h3F}, 4'b1111);
            checks++;
            if ({frame_tick, digit_en, seg} !== e) begin
                errors++;
                $display("FAIL noblank_0070 cyc=%0d got %b_%b_%h want %h",
                         k, frame_tick, digit_en, seg, e);
            end
        end
    endtask

    task automatic test_invalid();
        logic [11:0] e;
        digits = 16'h00A0;
        blank_zeros = 1'b1;
        hold_reset();
        for (int k = 1; k <= 25; k++) begin
            @(negedge sys_clk);
            e = exp_at(k - 1, {7'h3F, 7'h3F, 7'h40, 7'h3F}, 4'b0011);
            checks++;
            if ({frame_tick, digit_en, seg} !== e) begin
                errors++;
                $display("FAIL invalid_00A0 cyc=%0d got %b_%b_%h want %h",
                         k, frame_tick, digit_en, seg, e);
            end
        end
    endtask

    task automatic test_snapshot();
        logic [11:0] e;
        digits = 16'h1234;
        blank_zeros = 1'b0;
        hold_reset();
        for (int k = 1; k <= 50; k++) begin
            @(negedge sys_clk);
            if (k <= 25)
                e = exp_at(k - 1, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1111);
            else
                e = exp_at(k - 26, {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b1111);
            checks++;
            if ({frame_tick, digit_en, seg} !== e) begin
                errors++;
                $display("FAIL snapshot cyc=%0d got %b_%b_%h want %h",
                         k, frame_tick, digit_en, seg, e);
            end
            // cycle 9 is inside the digit-1 slot
            if (k == 9) digits = 16'h5678;
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] e;
        digits = 16'h1234;
        blank_zeros = 1'b0;
        hold_reset();
        repeat (15) @(negedge sys_clk);
        checks++;
        if ({digit_en, seg} !== {4'b0100, 7'h5B}) begin
            errors++;
            $display("FAIL pre_async cyc=15 got %b_%h want 0100_5b", digit_en, seg);
        end
        #2 sys_reset = 1'b1;
        #1;
        checks++;
        if ({frame_tick, digit_en, seg} !== 12'h000) begin
            errors++;
            $display("FAIL async_reset got %b_%b_%h want all 0", frame_tick, digit_en, seg);
        end
        repeat (2) @(negedge sys_clk);
        sys_reset = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge sys_clk);
            e = exp_at(k - 1, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1111);
            checks++;
            if ({frame_tick, digit_en, seg} !== e) begin
                errors++;
                $display("FAIL after_async cyc=%0d got %b_%b_%h want %h",
                         k, frame_tick, digit_en, seg, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_blanking();
        test_invalid();
        test_snapshot();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
